// File: rtl/vector_serializer.sv
// vector_serializer: buffers one N-element vector per handshake and streams it out one element per beat
module vector_serializer #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N*W-1:0]       vec_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [W-1:0]         elem_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N*W-1:0] buf_q, buf_d;
    logic           send, accept, beat;

    assign send        = state_q == SEND;
    assign out_valid_o = send;
    assign last_o      = send && idx_q == IW'(N - 1);
    assign idx_o       = send ? idx_q : '0;
    assign elem_o      = send ? buf_q[idx_q*W +: W] : '0;
    assign in_ready_o  = !send || (last_o && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign beat        = send && out_ready_i;

    // A capture always restarts at element 0; the last beat without a new vector empties the buffer
    always_comb begin
        state_d = accept ? SEND : (beat && last_o) ? IDLE : state_q;
        idx_d   = accept ? '0 : (beat && !last_o) ? idx_q + 1'b1 : idx_q;
        buf_d   = accept ? vec_i : buf_q;
    end

    // Control state; reset drops any partially sent vector
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Vector buffer; contents are only observed while streaming, so no reset
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_vector_serializer.sv
// tb_vector_serializer: table-driven cycle checks plus a random-backpressure sequence
module tb_vector_serializer;
    localparam int N = 8;
    localparam int W = 16;

    logic           clk, rst, in_valid, in_ready, last, out_valid, out_ready;
    logic [N*W-1:0] vec;
    logic [W-1:0]   elem;
    logic [2:0]     idx;

    int checks = 0;
    int errors = 0;

    vector_serializer #(.N(N), .W(W)) dut (
        .clk_i(clk), .rst_i(rst), .vec_i(vec), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .elem_o(elem), .idx_o(idx), .last_o(last), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst, iv;
        logic [N*W-1:0] vec;
        logic           ordy, chk, ir, ov;
        logic [W-1:0]   elem;
        logic [2:0]     idx;
        logic           last;
    } row_t;

    row_t tbl[$];

    localparam logic [N*W-1:0] V1 = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [N*W-1:0] VA = {16'h00A7, 16'h00A6, 16'h00A5, 16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    localparam logic [N*W-1:0] VB = {16'h00B7, 16'h00B6, 16'h00B5, 16'h00B4, 16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
    localparam logic [N*W-1:0] VF = {N{16'hFFFF}};
    localparam logic [N*W-1:0] VS = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

    task automatic add(input logic r_rst, r_iv, input logic [N*W-1:0] r_vec, input logic r_ordy, r_chk, r_ir, r_ov,
                       input logic [W-1:0] r_elem, input logic [2:0] r_idx, input logic r_last);
        row_t r;
        r.rst = r_rst; r.iv = r_iv; r.vec = r_vec; r.ordy = r_ordy; r.chk = r_chk;
        r.ir = r_ir; r.ov = r_ov; r.elem = r_elem; r.idx = r_idx; r.last = r_last;
        tbl.push_back(r);
    endtask

    task automatic idle_row();
        add(0, 0, '0, 1, 1, 1, 0, '0, 3'd0, 0);
    endtask

    task automatic accept_row(input logic [N*W-1:0] v);
        add(0, 1, v, 1, 1, 1, 0, '0, 3'd0, 0);
    endtask

    // Eight full-rate beats of v; in_valid is raised with nv from beat 'from' onward
    task automatic beats(input logic [N*W-1:0] v, input int from, input logic [N*W-1:0] nv);
        for (int k = 0; k < N; k++)
            add(0, k >= from, (k >= from) ? nv : '0, 1, 1, k == N - 1, 1, v[k*W +: W], k[2:0], k == N - 1);
    endtask

    task automatic apply(input row_t r, input int n);
        @(negedge clk);
        rst = r.rst; in_valid = r.iv; vec = r.vec; out_ready = r.ordy;
        #1;
        if (r.chk) begin
            checks++;
            if (in_ready !== r.ir || out_valid !== r.ov || elem !== r.elem || idx !== r.idx || last !== r.last) begin
                errors++;
                $display("FAIL row%0d: got ir=%b ov=%b elem=%h idx=%0d last=%b, want ir=%b ov=%b elem=%h idx=%0d last=%b",
                         n, in_ready, out_valid, elem, idx, last, r.ir, r.ov, r.elem, r.idx, r.last);
            end
        end
    endtask

    initial begin
        int k, i, got;
        logic p;
        rst = 1; in_valid = 0; vec = '0; out_ready = 0;
        add(1, 0, '0, 0, 0, 0, 0, '0, 3'd0, 0);
        idle_row();
        // single vector at full rate
        accept_row(V1);
        beats(V1, N, '0);
        idle_row();
        // backpressure pattern 1,0,0,1,0,0,...
        accept_row(V1);
        k = 0; i = 0;
        while (k < N) begin
            p = (i % 3) == 0;
            add(0, 0, '0, p, 1, (k == N - 1) && p, 1, V1[k*W +: W], k[2:0], k == N - 1);
            if (p) k++;
            i++;
        end
        idle_row();
        // back-to-back with in_valid held high
        accept_row(VA);
        beats(VA, 0, VB);
        beats(VB, N, '0);
        idle_row();
        // B presented from beat 3 of A, last beat of A stalled once
        accept_row(VA);
        for (int j = 0; j < N - 1; j++)
            add(0, j >= 3, (j >= 3) ? VB : '0, 1, 1, 0, 1, VA[j*W +: W], j[2:0], 0);
        add(0, 1, VB, 0, 1, 0, 1, 16'h00A7, 3'd7, 1);
        add(0, 1, VB, 1, 1, 1, 1, 16'h00A7, 3'd7, 1);
        beats(VB, N, '0);
        idle_row();
        // reset after beat idx 4, then reset colliding with a handshake
        accept_row(V1);
        for (int j = 0; j < 5; j++)
            add(0, 0, '0, 1, 1, 0, 1, V1[j*W +: W], j[2:0], 0);
        add(1, 0, '0, 1, 1, 0, 1, 16'h0006, 3'd5, 0);
        idle_row();
        add(1, 1, VF, 1, 1, 1, 0, '0, 3'd0, 0);
        idle_row();
        accept_row(VF);
        beats(VF, N, '0);
        idle_row();
        // bit-exact pass-through
        accept_row(VS);
        beats(VS, N, '0);
        idle_row();

        for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

        // random backpressure: order and count of beats must be preserved
        @(negedge clk);
        rst = 0; in_valid = 1; vec = V1; out_ready = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_accept: got in_ready=%b want 1", in_ready);
        end
        got = 0;
        for (int c = 0; c < 200 && got < N; c++) begin
            @(negedge clk);
            in_valid = 0; vec = '0; out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (elem !== V1[got*W +: W] || idx !== got[2:0]) begin
                    errors++;
                    $display("FAIL rand_beat%0d: got elem=%h idx=%0d want elem=%h idx=%0d", got, elem, idx, V1[got*W +: W], got);
                end
                got++;
            end
        end
        checks++;
        if (got != N) begin
            errors++;
            $display("FAIL rand_count: got %0d beats want %0d", got, N);
        end
        @(negedge clk);
        out_ready = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
